// File: rtl/mem_arb_pkg.sv
// Shared constants and types for the instruction/data memory port arbiter.
package mem_arb_pkg;

  localparam logic [2:0] RW_BYTE  = 3'b000;
  localparam logic [2:0] RW_HALF  = 3'b001;
  localparam logic [2:0] RW_WORD  = 3'b010;
  localparam logic [2:0] RW_BYTEU = 3'b100;
  localparam logic [2:0] RW_HALFU = 3'b101;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} arb_state_t;
  typedef enum logic {OWN_I, OWN_D} owner_t;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundle of I requester, D requester and memory-controller signals around the arbiter.
interface mem_port_arbiter_if;

  logic        i_req;
  logic [31:0] i_addr;
  logic        i_ack;
  logic [31:0] i_rdata;
  logic        d_req;
  logic        d_memrw;
  logic [2:0]  d_rwtype;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic        d_ack;
  logic [31:0] d_rdata;
  logic        mem_en;
  logic        mem_rw;
  logic [2:0]  mem_rwtype;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        busy;

  // master: requesters plus memory controller; slave: the arbiter itself
  modport master (
    output i_req, i_addr, d_req, d_memrw, d_rwtype, d_addr, d_wdata, mem_rdata,
    input  i_ack, i_rdata, d_ack, d_rdata, mem_en, mem_rw, mem_rwtype, mem_addr,
           mem_wdata, busy
  );

  modport slave (
    input  i_req, i_addr, d_req, d_memrw, d_rwtype, d_addr, d_wdata, mem_rdata,
    output i_ack, i_rdata, d_ack, d_rdata, mem_en, mem_rw, mem_rwtype, mem_addr,
           mem_wdata, busy
  );

endinterface

// File: rtl/mem_port_arbiter.sv
// Serialises I-fetch and D load/store onto one memory port, one access in flight,
// D priority with a starvation bound for I; ack arrives READ_LATENCY cycles after issue.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int READ_LATENCY = 1,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  mem_port_arbiter_if.slave bus
);

  localparam int              SW         = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
  localparam logic [SW-1:0]   STARVE_MAX = SW'(STARVE_LIMIT);
  localparam logic [2:0]      LAT_INIT   = 3'(READ_LATENCY - 1);

  arb_state_t    state;
  arb_state_t    state_nxt;
  owner_t        owner;
  logic [2:0]    lat_cnt;
  logic [SW-1:0] starve_cnt;
  logic          i_starved;
  logic          grant_d;
  logic          grant_i;

  always_comb begin
    i_starved = (STARVE_LIMIT != 0) && (starve_cnt == STARVE_MAX);
    grant_d   = bus.d_req && !(bus.i_req && i_starved);
    grant_i   = bus.i_req && !grant_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      owner      <= OWN_I;
      lat_cnt    <= '0;
      starve_cnt <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (grant_d || grant_i) begin
            owner   <= grant_d ? OWN_D : OWN_I;
            lat_cnt <= LAT_INIT;
          end
          // I waiting behind a D grant ages; anything else resets the count
          if (!bus.i_req || grant_i) begin
            starve_cnt <= '0;
          end else if (grant_d && (starve_cnt != STARVE_MAX)) begin
            starve_cnt <= starve_cnt + 1'b1;
          end
        end
        WAIT:    lat_cnt <= lat_cnt - 1'b1;
        default: ;
      endcase
    end
  end

  always_comb begin
    state_nxt      = state;
    bus.mem_en     = 1'b0;
    bus.mem_rw     = 1'b0;
    bus.mem_rwtype = 3'b000;
    bus.mem_addr   = '0;
    bus.mem_wdata  = '0;
    bus.i_ack      = 1'b0;
    bus.i_rdata    = '0;
    bus.d_ack      = 1'b0;
    bus.d_rdata    = '0;
    bus.busy       = 1'b0;
    // outputs are forced quiet while reset is asserted, even with requests pending
    if (rst_n) begin
      case (state)
        IDLE: begin
          if (grant_d) begin
            bus.mem_en     = 1'b1;
            bus.mem_rw     = bus.d_memrw;
            bus.mem_rwtype = bus.d_rwtype;
            bus.mem_addr   = bus.d_addr;
            bus.mem_wdata  = bus.d_memrw ? bus.d_wdata : 32'h0;
            state_nxt      = (READ_LATENCY == 1) ? RESP : WAIT;
          end else if (grant_i) begin
            bus.mem_en     = 1'b1;
            bus.mem_rwtype = RW_WORD;
            bus.mem_addr   = bus.i_addr;
            state_nxt      = (READ_LATENCY == 1) ? RESP : WAIT;
          end
        end
        WAIT: begin
          if (lat_cnt == 3'd1) state_nxt = RESP;
        end
        RESP: begin
          state_nxt = IDLE;
          if (owner == OWN_D) begin
            bus.d_ack   = 1'b1;
            bus.d_rdata = bus.mem_rdata;
          end else begin
            bus.i_ack   = 1'b1;
            bus.i_rdata = bus.mem_rdata;
          end
        end
        default: state_nxt = IDLE;
      endcase
      // the issue cycle already counts as an outstanding access
      bus.busy = (state != IDLE) || bus.mem_en;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench: three arbiter configurations (RL1/SL4, RL1/SL0, RL3/SL4).
module tb_mem_port_arbiter;
  import mem_arb_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad = 0;

  always #5 clk = ~clk;

  mem_port_arbiter_if a ();
  mem_port_arbiter_if b ();
  mem_port_arbiter_if c ();

  mem_port_arbiter #(.READ_LATENCY(1), .STARVE_LIMIT(4)) u_a (.clk(clk), .rst_n(rst_n), .bus(a.slave));
  mem_port_arbiter #(.READ_LATENCY(1), .STARVE_LIMIT(0)) u_b (.clk(clk), .rst_n(rst_n), .bus(b.slave));
  mem_port_arbiter #(.READ_LATENCY(3), .STARVE_LIMIT(4)) u_c (.clk(clk), .rst_n(rst_n), .bus(c.slave));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // inputs change 1 time unit after the rising edge; outputs are sampled 2 units later
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic look();
    #2;
  endtask

  initial begin
    a.i_req = 0; a.i_addr = 0; a.d_req = 0; a.d_memrw = 0; a.d_rwtype = 0;
    a.d_addr = 0; a.d_wdata = 0; a.mem_rdata = 32'hDEADBEEF;
    b.i_req = 0; b.i_addr = 0; b.d_req = 0; b.d_memrw = 0; b.d_rwtype = 0;
    b.d_addr = 0; b.d_wdata = 0; b.mem_rdata = 32'hDEADBEEF;
    c.i_req = 0; c.i_addr = 0; c.d_req = 0; c.d_memrw = 0; c.d_rwtype = 0;
    c.d_addr = 0; c.d_wdata = 0; c.mem_rdata = 32'hDEADBEEF;

    // reset state
    repeat (2) step();
    look();
    chk("rst_mem_en", 32'(a.mem_en), 32'd0);
    chk("rst_busy", 32'(a.busy), 32'd0);
    chk("rst_i_ack", 32'(a.i_ack), 32'd0);
    chk("rst_d_ack", 32'(a.d_ack), 32'd0);
    chk("rst_mem_addr", a.mem_addr, 32'd0);
    chk("rst_c_busy", 32'(c.busy), 32'd0);
    step();
    rst_n = 1'b1;

    // 1: I only
    step();
    a.i_req = 1; a.i_addr = 32'h100;
    look();
    chk("t1_mem_en", 32'(a.mem_en), 32'd1);
    chk("t1_mem_addr", a.mem_addr, 32'h100);
    chk("t1_mem_rw", 32'(a.mem_rw), 32'd0);
    chk("t1_rwtype", 32'(a.mem_rwtype), 32'(RW_WORD));
    chk("t1_i_rdata_idle", a.i_rdata, 32'd0);
    chk("t1_i_ack_early", 32'(a.i_ack), 32'd0);
    step();
    a.mem_rdata = 32'h00500093;
    look();
    chk("t1_i_ack", 32'(a.i_ack), 32'd1);
    chk("t1_i_rdata", a.i_rdata, 32'h00500093);
    chk("t1_d_ack", 32'(a.d_ack), 32'd0);
    chk("t1_no_reissue", 32'(a.mem_en), 32'd0);
    step();
    a.i_req = 0; a.mem_rdata = 32'hDEADBEEF;
    look();
    chk("t1_ack_pulse", 32'(a.i_ack), 32'd0);
    chk("t1_busy_after", 32'(a.busy), 32'd0);

    // 2: D byte store
    step();
    a.d_req = 1; a.d_memrw = 1; a.d_rwtype = RW_BYTE; a.d_addr = 32'h203; a.d_wdata = 32'hAB;
    look();
    chk("t2_mem_en", 32'(a.mem_en), 32'd1);
    chk("t2_mem_rw", 32'(a.mem_rw), 32'd1);
    chk("t2_rwtype", 32'(a.mem_rwtype), 32'd0);
    chk("t2_mem_addr", a.mem_addr, 32'h203);
    chk("t2_mem_wdata", a.mem_wdata, 32'hAB);
    step();
    look();
    chk("t2_d_ack", 32'(a.d_ack), 32'd1);
    chk("t2_i_ack", 32'(a.i_ack), 32'd0);
    step();
    a.d_req = 0; a.d_memrw = 0;
    look();

    // 3a: both requesting, starvation bound of 4
    step();
    a.i_req = 1; a.i_addr = 32'h100;
    a.d_req = 1; a.d_addr = 32'h200; a.d_wdata = 32'h55; a.d_rwtype = RW_WORD;
    for (int g = 0; g < 10; g++) begin
      logic exp_i;
      exp_i = ((g % 5) == 4);
      look();
      chk($sformatf("t3a_grant%0d_addr", g), a.mem_addr, exp_i ? 32'h100 : 32'h200);
      chk($sformatf("t3a_grant%0d_wdata", g), a.mem_wdata, 32'd0);
      step();
      look();
      chk($sformatf("t3a_grant%0d_i_ack", g), 32'(a.i_ack), 32'(exp_i));
      chk($sformatf("t3a_grant%0d_d_ack", g), 32'(a.d_ack), 32'(!exp_i));
      step();
    end
    a.i_req = 0; a.d_req = 0;
    look();
    chk("t3a_quiet", 32'(a.mem_en), 32'd0);

    // 3b: strict D priority
    step();
    b.i_req = 1; b.i_addr = 32'h100; b.d_req = 1; b.d_addr = 32'h200;
    for (int g = 0; g < 6; g++) begin
      look();
      chk($sformatf("t3b_grant%0d_addr", g), b.mem_addr, 32'h200);
      step();
      look();
      chk($sformatf("t3b_grant%0d_i_ack", g), 32'(b.i_ack), 32'd0);
      chk($sformatf("t3b_grant%0d_d_ack", g), 32'(b.d_ack), 32'd1);
      step();
    end
    b.d_req = 0;
    look();
    chk("t3b_i_grant_addr", b.mem_addr, 32'h100);
    chk("t3b_i_grant_en", 32'(b.mem_en), 32'd1);
    step();
    look();
    chk("t3b_i_ack", 32'(b.i_ack), 32'd1);
    step();
    b.i_req = 0;

    // 4: read latency 3
    step();
    c.d_req = 1; c.d_memrw = 0; c.d_rwtype = RW_WORD; c.d_addr = 32'h40;
    look();
    chk("t4_issue_en", 32'(c.mem_en), 32'd1);
    chk("t4_issue_busy", 32'(c.busy), 32'd1);
    chk("t4_issue_addr", c.mem_addr, 32'h40);
    for (int k = 1; k <= 2; k++) begin
      step();
      look();
      chk($sformatf("t4_wait%0d_en", k), 32'(c.mem_en), 32'd0);
      chk($sformatf("t4_wait%0d_ack", k), 32'(c.d_ack), 32'd0);
      chk($sformatf("t4_wait%0d_busy", k), 32'(c.busy), 32'd1);
    end
    step();
    c.mem_rdata = 32'h12345678;
    look();
    chk("t4_d_ack", 32'(c.d_ack), 32'd1);
    chk("t4_d_rdata", c.d_rdata, 32'h12345678);
    chk("t4_resp_busy", 32'(c.busy), 32'd1);
    chk("t4_resp_en", 32'(c.mem_en), 32'd0);
    step();
    c.d_req = 0; c.mem_rdata = 32'hDEADBEEF;
    look();
    chk("t4_done_busy", 32'(c.busy), 32'd0);
    chk("t4_done_ack", 32'(c.d_ack), 32'd0);

    // 5: reset during WAIT
    step();
    c.i_req = 1; c.i_addr = 32'h80;
    look();
    chk("t5_issue_en", 32'(c.mem_en), 32'd1);
    step();
    look();
    chk("t5_wait_busy", 32'(c.busy), 32'd1);
    step();
    rst_n = 1'b0;
    look();
    chk("t5_rst_busy", 32'(c.busy), 32'd0);
    chk("t5_rst_en", 32'(c.mem_en), 32'd0);
    chk("t5_rst_i_ack", 32'(c.i_ack), 32'd0);
    chk("t5_rst_addr", c.mem_addr, 32'd0);
    step();
    c.i_req = 0;
    look();
    chk("t5_rst_hold_ack", 32'(c.i_ack), 32'd0);
    step();
    rst_n = 1'b1;
    for (int k = 0; k < 5; k++) begin
      look();
      chk($sformatf("t5_post%0d_i_ack", k), 32'(c.i_ack), 32'd0);
      chk($sformatf("t5_post%0d_busy", k), 32'(c.busy), 32'd0);
      step();
    end
    c.i_req = 1; c.i_addr = 32'h84;
    look();
    chk("t5_new_en", 32'(c.mem_en), 32'd1);
    chk("t5_new_addr", c.mem_addr, 32'h84);
    repeat (3) step();
    c.mem_rdata = 32'hCAFEF00D;
    look();
    chk("t5_new_i_ack", 32'(c.i_ack), 32'd1);
    chk("t5_new_i_rdata", c.i_rdata, 32'hCAFEF00D);
    step();
    c.i_req = 0;
    look();

    // 6: idle
    for (int k = 0; k < 20; k++) begin
      step();
      look();
      chk("t6_mem_en", 32'(a.mem_en), 32'd0);
      chk("t6_i_ack", 32'(a.i_ack), 32'd0);
      chk("t6_d_ack", 32'(a.d_ack), 32'd0);
      chk("t6_busy", 32'(a.busy), 32'd0);
      chk("t6_mem_addr", a.mem_addr, 32'd0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
